// File: rtl/uart_txrx.sv
// uart_txrx: independent UART transmitter and receiver sharing one clock.
//   Parameters: FREQ_CLKIN, BAUD_RATE, DATA_BITS (5..8), PARITY (0 none, 1 odd, 2 even),
//               STOP_BITS (1..2). One bit = FREQ_CLKIN/BAUD_RATE clocks; RX oversamples 16x.
//   Ports: clk, rst (sync, active-high), data_in/wr_en (TX load), tx/tx_busy (TX line/status),
//          rx (async serial in), rx_data/rx_valid/rx_frame_err/rx_parity_err (RX result).
//   Optional: define UART_TXRX_LOOPBACK_EN to add input 'loopback'; when high the receiver
//             listens to the internal tx line instead of rx.
module uart_txrx #(
  parameter int unsigned FREQ_CLKIN = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 wr_en,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
`ifdef UART_TXRX_LOOPBACK_EN
  input  logic                 loopback,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err
);
  localparam int unsigned ClksPerBit = FREQ_CLKIN / BAUD_RATE;
  localparam int unsigned OsDiv      = ClksPerBit / 16;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned OsW        = (OsDiv > 1) ? $clog2(OsDiv) : 1;

  if (OsDiv < 1 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : gen_param_check
    $error("uart_txrx: illegal parameter combination");
  end

  // ---------------------------------------------------------------- TX
  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_e;
  tx_state_e            tx_state_q, tx_state_d;
  logic [CntW-1:0]      tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == CntW'(ClksPerBit - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TxIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    if (tx_state_q != TxIdle) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    unique case (tx_state_q)
      TxIdle: begin
        if (wr_en) begin
          tx_state_d = TxStart;
          tx_shift_d = data_in;
          tx_par_d   = (PARITY == 1) ? ~^data_in : ^data_in;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
        end
      end
      TxStart: if (tx_bit_end) tx_state_d = TxData;
      TxData: begin
        if (tx_bit_end) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'(DATA_BITS - 1)) begin
            tx_bit_d   = '0;
            tx_state_d = (PARITY != 0) ? TxParity : TxStop;
          end
        end
      end
      TxParity: if (tx_bit_end) tx_state_d = TxStop;
      TxStop: begin
        // tx_bit_q is reused to count stop bits
        if (tx_bit_end) begin
          tx_bit_d = tx_bit_q + 3'd1;
          if (tx_bit_q == 3'(STOP_BITS - 1)) begin
            tx_bit_d   = '0;
            tx_state_d = TxIdle;
          end
        end
      end
      default: tx_state_d = TxIdle;
    endcase
  end

  always_comb begin
    tx      = 1'b1;
    tx_busy = 1'b1;
    unique case (tx_state_q)
      TxIdle:   tx_busy = 1'b0;
      TxStart:  tx      = 1'b0;
      TxData:   tx      = tx_shift_q[0];
      TxParity: tx      = tx_par_q;
      default:  tx      = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------- RX
  logic rx_src, rx_meta_q, rx_sync_q, rx_prev_q;
`ifdef UART_TXRX_LOOPBACK_EN
  assign rx_src = loopback ? tx : rx;
`else
  assign rx_src = rx;
`endif

  logic [OsW-1:0] os_cnt_q;
  logic           os_tick;
  assign os_tick = (os_cnt_q == OsW'(OsDiv - 1));

  typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxParity, RxStop} rx_state_e;
  rx_state_e            rx_state_q, rx_state_d;
  logic [3:0]           rx_tick_q, rx_tick_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
  logic                 rx_par_q, rx_par_d;
  logic                 rx_mid, rx_end, rx_done, rx_par_bad;

  assign rx_mid = os_tick && (rx_tick_q == 4'd7);
  assign rx_end = os_tick && (rx_tick_q == 4'd15);

  always_ff @(posedge clk) begin
    if (rst) begin
      // Synchroniser presets to the idle line level so reset release is not an edge
      rx_meta_q     <= 1'b1;
      rx_sync_q     <= 1'b1;
      rx_prev_q     <= 1'b1;
      os_cnt_q      <= '0;
      rx_state_q    <= RxIdle;
      rx_tick_q     <= '0;
      rx_bit_q      <= '0;
      rx_shift_q    <= '0;
      rx_par_q      <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_meta_q  <= rx_src;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      os_cnt_q   <= os_tick ? '0 : os_cnt_q + 1'b1;
      rx_state_q <= rx_state_d;
      rx_tick_q  <= rx_tick_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_valid   <= rx_done;
      if (rx_done) begin
        rx_data       <= rx_shift_q;
        rx_frame_err  <= ~rx_sync_q;
        rx_parity_err <= rx_par_bad;
      end
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tick_d  = rx_tick_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    if (rx_state_q != RxIdle && os_tick) rx_tick_d = rx_tick_q + 4'd1;
    unique case (rx_state_q)
      RxIdle: begin
        // Falling edge only: a held-low line (break) cannot re-arm until it goes high
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RxStart;
          rx_tick_d  = '0;
          rx_bit_d   = '0;
        end
      end
      RxStart: begin
        if (rx_mid && rx_sync_q) rx_state_d = RxIdle;
        else if (rx_end)         rx_state_d = RxData;
      end
      RxData: begin
        if (rx_mid) rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
        if (rx_end) begin
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'(DATA_BITS - 1)) begin
            rx_bit_d   = '0;
            rx_state_d = (PARITY != 0) ? RxParity : RxStop;
          end
        end
      end
      RxParity: begin
        if (rx_mid) rx_par_d = rx_sync_q;
        if (rx_end) rx_state_d = RxStop;
      end
      RxStop:  if (rx_mid) rx_state_d = RxIdle;
      default: rx_state_d = RxIdle;
    endcase
  end

  always_comb begin
    rx_done    = (rx_state_q == RxStop) && rx_mid;
    rx_par_bad = (PARITY == 0) ? 1'b0 : ((^{rx_shift_q, rx_par_q}) ^ (PARITY == 1));
  end

endmodule

// File: tb/tb_uart_txrx.sv
module tb_uart_txrx;
  localparam int unsigned Freq = 1_600_000;
  localparam int unsigned Baud = 100_000;
  localparam int          Cpb  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // u_dut_n: 8N1, u_dut_e: 8E1
  logic [7:0] data_in_n, data_in_e, rx_data_n, rx_data_e;
  logic wr_en_n, wr_en_e, tx_n, tx_e, tx_busy_n, tx_busy_e, rx_n, rx_e;
  logic rx_valid_n, rx_valid_e, fe_n, fe_e, pe_n, pe_e;
`ifdef UART_TXRX_LOOPBACK_EN
  logic loopback_n, loopback_e;
`endif

  uart_txrx #(.FREQ_CLKIN(Freq), .BAUD_RATE(Baud), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
  u_dut_n (
    .clk(clk), .rst(rst), .data_in(data_in_n), .wr_en(wr_en_n), .tx(tx_n),
    .tx_busy(tx_busy_n), .rx(rx_n),
`ifdef UART_TXRX_LOOPBACK_EN
    .loopback(loopback_n),
`endif
    .rx_data(rx_data_n), .rx_valid(rx_valid_n), .rx_frame_err(fe_n), .rx_parity_err(pe_n)
  );

  uart_txrx #(.FREQ_CLKIN(Freq), .BAUD_RATE(Baud), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1))
  u_dut_e (
    .clk(clk), .rst(rst), .data_in(data_in_e), .wr_en(wr_en_e), .tx(tx_e),
    .tx_busy(tx_busy_e), .rx(rx_e),
`ifdef UART_TXRX_LOOPBACK_EN
    .loopback(loopback_e),
`endif
    .rx_data(rx_data_e), .rx_valid(rx_valid_e), .rx_frame_err(fe_e), .rx_parity_err(pe_e)
  );

  int checks = 0;
  int errors = 0;

  // Records every rx_valid pulse of the 8E1 receiver
  int         vcnt_e = 0;
  logic [7:0] vdata_e = '0;
  logic       vfe_e = 1'b0, vpe_e = 1'b0;
  always @(negedge clk) begin
    if (rx_valid_e === 1'b1) begin
      vcnt_e  <= vcnt_e + 1;
      vdata_e <= rx_data_e;
      vfe_e   <= fe_e;
      vpe_e   <= pe_e;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks a TX frame cycle by cycle; optionally pulses wr_en_n at loop index inj_at.
  task automatic tx_frame(input bit on_e, input logic [7:0] d, input int inj_at,
                          input logic [7:0] inj_d);
    logic [10:0] bits;
    int          nb;
    logic        t_obs, b_obs;
    bits      = 11'h7ff;
    bits[0]   = 1'b0;
    bits[8:1] = d;
    nb        = 10;
    if (on_e) begin
      bits[9] = ^d;
      nb      = 11;
    end
    for (int i = 0; i < nb * Cpb; i++) begin
      t_obs = on_e ? tx_e : tx_n;
      b_obs = on_e ? tx_busy_e : tx_busy_n;
      chk("tx_bit", 32'(t_obs), 32'(bits[i / Cpb]));
      chk("tx_busy_frame", 32'(b_obs), 32'd1);
      if (i == inj_at) begin
        wr_en_n   = 1'b1;
        data_in_n = inj_d;
      end
      step(1);
      wr_en_n = 1'b0;
    end
    t_obs = on_e ? tx_e : tx_n;
    b_obs = on_e ? tx_busy_e : tx_busy_n;
    chk("tx_busy_after", 32'(b_obs), 32'd0);
    chk("tx_idle_after", 32'(t_obs), 32'd1);
  endtask

  // Drives an 8E1 frame into u_dut_e, then a short idle gap
  task automatic rx_send(input logic [7:0] d, input logic par, input logic stop_lvl,
                         input int stop_cycles);
    logic [9:0] bits;
    bits = {par, d, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rx_e = bits[b];
      step(Cpb);
    end
    rx_e = stop_lvl;
    step(stop_cycles);
    rx_e = 1'b1;
    step(Cpb);
  endtask

  int base;

  initial begin
    rst = 1'b1;
    data_in_n = '0; data_in_e = '0; wr_en_n = 1'b0; wr_en_e = 1'b0;
    rx_n = 1'b1; rx_e = 1'b1;
`ifdef UART_TXRX_LOOPBACK_EN
    loopback_n = 1'b0; loopback_e = 1'b0;
`endif
    step(3);
    rst = 1'b0;
    step(2);

    // Reset state
    chk("rst_tx_n", 32'(tx_n), 32'd1);
    chk("rst_busy_n", 32'(tx_busy_n), 32'd0);
    chk("rst_tx_e", 32'(tx_e), 32'd1);
    chk("rst_busy_e", 32'(tx_busy_e), 32'd0);
    chk("rst_valid_e", 32'(rx_valid_e), 32'd0);
    chk("rst_data_e", 32'(rx_data_e), 32'h00);
    chk("rst_fe_e", 32'(fe_e), 32'd0);
    chk("rst_pe_e", 32'(pe_e), 32'd0);
    chk("rst_data_n", 32'(rx_data_n), 32'h00);

    // 8N1 TX of 0x55
    wr_en_n = 1'b1; data_in_n = 8'h55;
    step(1);
    wr_en_n = 1'b0;
    tx_frame(1'b0, 8'h55, -1, 8'h00);

    // 8E1 TX of 0x57 (five ones -> parity bit 1)
    wr_en_e = 1'b1; data_in_e = 8'h57;
    step(1);
    wr_en_e = 1'b0; data_in_e = 8'h00;
    tx_frame(1'b1, 8'h57, -1, 8'h00);

    // Write during busy ignored, then back-to-back write in the busy-fall cycle
    step(3);
    wr_en_n = 1'b1; data_in_n = 8'h12;
    step(1);
    wr_en_n = 1'b0;
    tx_frame(1'b0, 8'h12, 50, 8'h34);
    wr_en_n = 1'b1; data_in_n = 8'h34;
    step(1);
    wr_en_n = 1'b0; data_in_n = 8'h00;
    tx_frame(1'b0, 8'h34, -1, 8'h00);

    // 8E1 RX of 0xA3, correct parity (four ones -> 0)
    base = vcnt_e;
    rx_send(8'hA3, 1'b0, 1'b1, Cpb);
    chk("rx_a3_count", 32'(vcnt_e - base), 32'd1);
    chk("rx_a3_data", 32'(vdata_e), 32'hA3);
    chk("rx_a3_fe", 32'(vfe_e), 32'd0);
    chk("rx_a3_pe", 32'(vpe_e), 32'd0);
    chk("rx_a3_hold", 32'(rx_data_e), 32'hA3);
    chk("rx_valid_low", 32'(rx_valid_e), 32'd0);

    // Same payload with wrong parity
    base = vcnt_e;
    rx_send(8'hA3, 1'b1, 1'b1, Cpb);
    chk("rx_bad_par_count", 32'(vcnt_e - base), 32'd1);
    chk("rx_bad_par_data", 32'(vdata_e), 32'hA3);
    chk("rx_bad_par_pe", 32'(vpe_e), 32'd1);
    chk("rx_bad_par_fe", 32'(vfe_e), 32'd0);
    chk("rx_pe_hold", 32'(pe_e), 32'd1);

    // 6-cycle glitch is a false start, then 0x0F (four ones -> parity 0)
    base = vcnt_e;
    rx_e = 1'b0;
    step(6);
    rx_e = 1'b1;
    step(40);
    chk("rx_glitch_count", 32'(vcnt_e - base), 32'd0);
    rx_send(8'h0F, 1'b0, 1'b1, Cpb);
    chk("rx_0f_count", 32'(vcnt_e - base), 32'd1);
    chk("rx_0f_data", 32'(vdata_e), 32'h0F);
    chk("rx_0f_fe", 32'(vfe_e), 32'd0);
    chk("rx_0f_pe", 32'(vpe_e), 32'd0);

    // Break: 0x00, parity 0, stop held low 40 cycles
    base = vcnt_e;
    rx_send(8'h00, 1'b0, 1'b0, 40);
    chk("rx_break_count", 32'(vcnt_e - base), 32'd1);
    chk("rx_break_data", 32'(vdata_e), 32'h00);
    chk("rx_break_fe", 32'(vfe_e), 32'd1);
    chk("rx_break_pe", 32'(vpe_e), 32'd0);
    rx_send(8'h5A, 1'b0, 1'b1, Cpb);
    chk("rx_rearm_count", 32'(vcnt_e - base), 32'd2);
    chk("rx_rearm_data", 32'(vdata_e), 32'h5A);
    chk("rx_rearm_fe", 32'(vfe_e), 32'd0);

    // Reset in the middle of an RX frame yields no pulse
    base = vcnt_e;
    rx_e = 1'b0;
    step(100);
    rst  = 1'b1;
    rx_e = 1'b1;
    step(2);
    rst = 1'b0;
    step(250);
    chk("rx_rst_count", 32'(vcnt_e - base), 32'd0);
    chk("rx_rst_data", 32'(rx_data_e), 32'h00);
    chk("rx_rst_fe", 32'(fe_e), 32'd0);

    // Reset at cycle 70 of a TX frame; wr_en during reset ignored
    wr_en_n = 1'b1; data_in_n = 8'hFF;
    step(1);
    wr_en_n = 1'b0;
    step(69);
    chk("tx_mid_busy", 32'(tx_busy_n), 32'd1);
    rst = 1'b1;
    wr_en_n = 1'b1; data_in_n = 8'h00;
    step(1);
    chk("tx_rst_tx", 32'(tx_n), 32'd1);
    chk("tx_rst_busy", 32'(tx_busy_n), 32'd0);
    step(1);
    chk("tx_rst_wr_busy", 32'(tx_busy_n), 32'd0);
    rst = 1'b0;
    wr_en_n = 1'b0;
    step(1);
    chk("tx_post_rst_busy", 32'(tx_busy_n), 32'd0);
    chk("tx_post_rst_tx", 32'(tx_n), 32'd1);

`ifdef UART_TXRX_LOOPBACK_EN
    // Loopback: TX 0xC6 (four ones -> parity 0) received internally
    base = vcnt_e;
    loopback_e = 1'b1;
    step(2);
    wr_en_e = 1'b1; data_in_e = 8'hC6;
    step(1);
    wr_en_e = 1'b0;
    step(250);
    chk("lb_count", 32'(vcnt_e - base), 32'd1);
    chk("lb_data", 32'(vdata_e), 32'hC6);
    chk("lb_fe", 32'(vfe_e), 32'd0);
    chk("lb_pe", 32'(vpe_e), 32'd0);
    loopback_e = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
